// File: rtl/sc_button_transition_pulse_pkg.sv
// Shared types and constants for the button transition pulse front end:
// FSM state encoding, repeat-phase flags and a width helper for the counters.
package sc_btnpulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam logic PH_DELAY  = 1'b0;
    localparam logic PH_PERIOD = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sc_button_transition_pulse_if.sv
// Button-side bundle: raw active-low button in, conditioned strobe and level out,
// plus the FSM state for observation.
interface sc_button_transition_pulse_if;
    import sc_btnpulse_pkg::*;

    // No handshake: button is a free-running level, upcount is a one-cycle
    // active-low strobe, pressed is a level; none wait on the other side.
    logic       SC_BTNPULSE_button_InLow;
    logic       SC_BTNPULSE_upcount_OutLow;
    logic       SC_BTNPULSE_pressed_OutHigh;
    btn_state_t SC_BTNPULSE_state;

    modport master (
        output SC_BTNPULSE_button_InLow,
        input  SC_BTNPULSE_upcount_OutLow,
        input  SC_BTNPULSE_pressed_OutHigh,
        input  SC_BTNPULSE_state
    );

    modport slave (
        input  SC_BTNPULSE_button_InLow,
        output SC_BTNPULSE_upcount_OutLow,
        output SC_BTNPULSE_pressed_OutHigh,
        output SC_BTNPULSE_state
    );

endinterface

// File: rtl/sc_button_transition_pulse_sync2.sv
// Two-flop synchronizer for the raw button; reset parks the output at 1
// (released) so a held key must be re-sampled after reset.
module sc_sync2 (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic stage1;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            stage1 <= 1'b1;
            q      <= 1'b1;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/sc_button_transition_pulse.sv
// Debounces an active-low button and emits a one-cycle active-low upcount
// strobe per accepted press, with optional auto-repeat while held.
module sc_button_transition_pulse
    import sc_btnpulse_pkg::*;
#(
    parameter int BTNPULSE_DEBOUNCE_CYCLES = 50000,
    parameter int BTNPULSE_REPEAT_DELAY    = 25000000,
    parameter int BTNPULSE_REPEAT_PERIOD   = 10000000
) (
    input logic                          SC_BTNPULSE_CLOCK_50,
    input logic                          SC_BTNPULSE_RESET_InLow,
    sc_button_transition_pulse_if.slave  btnIf
);

    localparam int CW = clog2(max3(BTNPULSE_DEBOUNCE_CYCLES, BTNPULSE_REPEAT_DELAY,
                                   BTNPULSE_REPEAT_PERIOD)) + 1;
    localparam bit REPEAT_EN = (BTNPULSE_REPEAT_DELAY != 0);
    // Clamp the "last" values so a disabled repeat does not produce a negative cast.
    localparam int DELAY_M1  = (BTNPULSE_REPEAT_DELAY  > 0) ? BTNPULSE_REPEAT_DELAY  - 1 : 0;
    localparam int PERIOD_M1 = (BTNPULSE_REPEAT_PERIOD > 0) ? BTNPULSE_REPEAT_PERIOD - 1 : 0;

    localparam logic [CW-1:0] DEB_LAST    = CW'(BTNPULSE_DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_M1);
    localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD_M1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    logic          syncN;
    btn_state_t    state, stateNext;
    logic [CW-1:0] dcnt, dcntNext;
    logic [CW-1:0] rcnt, rcntNext;
    logic          phase, phaseNext;
    logic          strobeNext;
    logic [CW-1:0] repeatLast;
    logic          upcountN;
    logic          pressed;

    sc_sync2 u_sync (
        .clk  (SC_BTNPULSE_CLOCK_50),
        .rstN (SC_BTNPULSE_RESET_InLow),
        .d    (btnIf.SC_BTNPULSE_button_InLow),
        .q    (syncN)
    );

    assign repeatLast = (phase == PH_PERIOD) ? PERIOD_LAST : DELAY_LAST;

    always_comb begin
        stateNext  = state;
        dcntNext   = dcnt;
        rcntNext   = rcnt;
        phaseNext  = phase;
        strobeNext = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!syncN) begin
                    stateNext = ST_PRESS_WAIT;
                    dcntNext  = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (syncN) begin
                    stateNext = ST_IDLE;
                end else if (dcnt == DEB_LAST) begin
                    stateNext  = ST_HELD;
                    strobeNext = 1'b1;
                    rcntNext   = '0;
                    phaseNext  = PH_DELAY;
                end else begin
                    dcntNext = dcnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                // Release takes priority, so a coincident repeat match is dropped.
                if (syncN) begin
                    stateNext = ST_RELEASE_WAIT;
                    dcntNext  = '0;
                end else if (REPEAT_EN) begin
                    if (rcnt == repeatLast) begin
                        strobeNext = 1'b1;
                        rcntNext   = '0;
                        phaseNext  = PH_PERIOD;
                    end else begin
                        rcntNext = rcnt + CNT_ONE;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (!syncN) begin
                    stateNext = ST_HELD;
                    rcntNext  = '0;
                    phaseNext = PH_DELAY;
                end else if (dcnt == DEB_LAST) begin
                    stateNext = ST_IDLE;
                end else begin
                    dcntNext = dcnt + CNT_ONE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge SC_BTNPULSE_CLOCK_50) begin
        if (!SC_BTNPULSE_RESET_InLow) begin
            state    <= ST_IDLE;
            dcnt     <= '0;
            rcnt     <= '0;
            phase    <= PH_DELAY;
            upcountN <= 1'b1;
            pressed  <= 1'b0;
        end else begin
            state    <= stateNext;
            dcnt     <= dcntNext;
            rcnt     <= rcntNext;
            phase    <= phaseNext;
            upcountN <= ~strobeNext;
            pressed  <= (stateNext == ST_HELD) || (stateNext == ST_RELEASE_WAIT);
        end
    end

    assign btnIf.SC_BTNPULSE_upcount_OutLow  = upcountN;
    assign btnIf.SC_BTNPULSE_pressed_OutHigh = pressed;
    assign btnIf.SC_BTNPULSE_state           = state;

endmodule

// File: tb/tb_sc_button_transition_pulse.sv
// Directed bench: instance A has auto-repeat (D=4, DELAY=8, PERIOD=3),
// instance B has repeat disabled (D=4, DELAY=0).
module tb_sc_button_transition_pulse;
    import sc_btnpulse_pkg::*;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;

    sc_button_transition_pulse_if ifA ();
    sc_button_transition_pulse_if ifB ();

    sc_button_transition_pulse #(
        .BTNPULSE_DEBOUNCE_CYCLES (4),
        .BTNPULSE_REPEAT_DELAY    (8),
        .BTNPULSE_REPEAT_PERIOD   (3)
    ) dutA (
        .SC_BTNPULSE_CLOCK_50    (clk),
        .SC_BTNPULSE_RESET_InLow (rstN),
        .btnIf                   (ifA)
    );

    sc_button_transition_pulse #(
        .BTNPULSE_DEBOUNCE_CYCLES (4),
        .BTNPULSE_REPEAT_DELAY    (0),
        .BTNPULSE_REPEAT_PERIOD   (3)
    ) dutB (
        .SC_BTNPULSE_CLOCK_50    (clk),
        .SC_BTNPULSE_RESET_InLow (rstN),
        .btnIf                   (ifB)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        ifA.SC_BTNPULSE_button_InLow = 1'b0;
        ifB.SC_BTNPULSE_button_InLow = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ifA.SC_BTNPULSE_upcount_OutLow !== 1'b1 || ifA.SC_BTNPULSE_pressed_OutHigh !== 1'b0) begin
                errors++;
                $display("FAIL reset_a cycle %0d upcount=%b pressed=%b expected 1/0", i,
                         ifA.SC_BTNPULSE_upcount_OutLow, ifA.SC_BTNPULSE_pressed_OutHigh);
            end
            checks++;
            if (ifB.SC_BTNPULSE_upcount_OutLow !== 1'b1 || ifB.SC_BTNPULSE_pressed_OutHigh !== 1'b0) begin
                errors++;
                $display("FAIL reset_b cycle %0d upcount=%b pressed=%b expected 1/0", i,
                         ifB.SC_BTNPULSE_upcount_OutLow, ifB.SC_BTNPULSE_pressed_OutHigh);
            end
            checks++;
            if (ifA.SC_BTNPULSE_state !== ST_IDLE) begin
                errors++;
                $display("FAIL reset_state cycle %0d state=%0d expected %0d", i,
                         ifA.SC_BTNPULSE_state, ST_IDLE);
            end
        end
        ifA.SC_BTNPULSE_button_InLow = 1'b1;
        ifB.SC_BTNPULSE_button_InLow = 1'b1;
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ifB.SC_BTNPULSE_state !== ST_IDLE || ifB.SC_BTNPULSE_pressed_OutHigh !== 1'b0) begin
            errors++;
            $display("FAIL reset_release state=%0d pressed=%b expected IDLE/0",
                     ifB.SC_BTNPULSE_state, ifB.SC_BTNPULSE_pressed_OutHigh);
        end
    endtask

    task automatic test_clean_press();
        logic expUp;
        logic expPr;
        for (int i = 0; i < 20; i++) begin
            ifB.SC_BTNPULSE_button_InLow = 1'b0;
            tick();
            expUp = (i == 6) ? 1'b0 : 1'b1;
            expPr = (i >= 6);
            checks++;
            if (ifB.SC_BTNPULSE_upcount_OutLow !== expUp || ifB.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL clean_press cycle %0d upcount=%b pressed=%b expected %b/%b", i,
                         ifB.SC_BTNPULSE_upcount_OutLow, ifB.SC_BTNPULSE_pressed_OutHigh, expUp, expPr);
            end
        end
        for (int i = 0; i < 10; i++) begin
            ifB.SC_BTNPULSE_button_InLow = 1'b1;
            tick();
            expPr = (i < 6);
            checks++;
            if (ifB.SC_BTNPULSE_upcount_OutLow !== 1'b1 || ifB.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL clean_release cycle %0d upcount=%b pressed=%b expected 1/%b", i,
                         ifB.SC_BTNPULSE_upcount_OutLow, ifB.SC_BTNPULSE_pressed_OutHigh, expPr);
            end
        end
    endtask

    task automatic test_bounce();
        logic expUp;
        logic expPr;
        for (int i = 0; i < 25; i++) begin
            ifB.SC_BTNPULSE_button_InLow = (i == 3 || i == 6) ? 1'b1 : 1'b0;
            tick();
            expUp = (i == 13) ? 1'b0 : 1'b1;
            expPr = (i >= 13);
            checks++;
            if (ifB.SC_BTNPULSE_upcount_OutLow !== expUp || ifB.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL bounce cycle %0d upcount=%b pressed=%b expected %b/%b", i,
                         ifB.SC_BTNPULSE_upcount_OutLow, ifB.SC_BTNPULSE_pressed_OutHigh, expUp, expPr);
            end
        end
        ifB.SC_BTNPULSE_button_InLow = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (ifB.SC_BTNPULSE_pressed_OutHigh !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release pressed=%b expected 0", ifB.SC_BTNPULSE_pressed_OutHigh);
        end
    endtask

    // Release is first sampled at E21; it reaches the FSM at E23, the same
    // edge as the next repeat match, which must be suppressed.
    task automatic test_auto_repeat();
        logic expUp;
        logic expPr;
        for (int i = 0; i < 32; i++) begin
            ifA.SC_BTNPULSE_button_InLow = (i < 21) ? 1'b0 : 1'b1;
            tick();
            expUp = (i == 6 || i == 14 || i == 17 || i == 20) ? 1'b0 : 1'b1;
            expPr = (i >= 6 && i < 27);
            checks++;
            if (ifA.SC_BTNPULSE_upcount_OutLow !== expUp || ifA.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL auto_repeat cycle %0d upcount=%b pressed=%b expected %b/%b", i,
                         ifA.SC_BTNPULSE_upcount_OutLow, ifA.SC_BTNPULSE_pressed_OutHigh, expUp, expPr);
            end
        end
    endtask

    task automatic test_release_glitch();
        logic expUp;
        logic expPr;
        for (int i = 0; i < 41; i++) begin
            ifA.SC_BTNPULSE_button_InLow = (i == 10 || i == 11 || i >= 29) ? 1'b1 : 1'b0;
            tick();
            expUp = (i == 6 || i == 22 || i == 25 || i == 28) ? 1'b0 : 1'b1;
            expPr = (i >= 6 && i < 35);
            checks++;
            if (ifA.SC_BTNPULSE_upcount_OutLow !== expUp || ifA.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL release_glitch cycle %0d upcount=%b pressed=%b expected %b/%b", i,
                         ifA.SC_BTNPULSE_upcount_OutLow, ifA.SC_BTNPULSE_pressed_OutHigh, expUp, expPr);
            end
        end
        checks++;
        if (ifA.SC_BTNPULSE_state !== ST_IDLE) begin
            errors++;
            $display("FAIL glitch_end state=%0d expected %0d", ifA.SC_BTNPULSE_state, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid();
        logic expUp;
        logic expPr;
        for (int i = 0; i < 25; i++) begin
            ifB.SC_BTNPULSE_button_InLow = 1'b0;
            rstN = (i == 3 || i == 14) ? 1'b0 : 1'b1;
            tick();
            expUp = (i == 10 || i == 21) ? 1'b0 : 1'b1;
            expPr = (i >= 10 && i < 14) || (i >= 21);
            checks++;
            if (ifB.SC_BTNPULSE_upcount_OutLow !== expUp || ifB.SC_BTNPULSE_pressed_OutHigh !== expPr) begin
                errors++;
                $display("FAIL reset_mid cycle %0d upcount=%b pressed=%b expected %b/%b", i,
                         ifB.SC_BTNPULSE_upcount_OutLow, ifB.SC_BTNPULSE_pressed_OutHigh, expUp, expPr);
            end
        end
        rstN = 1'b1;
        ifB.SC_BTNPULSE_button_InLow = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (ifB.SC_BTNPULSE_state !== ST_IDLE || ifB.SC_BTNPULSE_pressed_OutHigh !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_end state=%0d pressed=%b expected IDLE/0",
                     ifB.SC_BTNPULSE_state, ifB.SC_BTNPULSE_pressed_OutHigh);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstN = 1'b0;
        ifA.SC_BTNPULSE_button_InLow = 1'b1;
        ifB.SC_BTNPULSE_button_InLow = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_release_glitch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
